instruction_fetch: RTL and testbench

Fetch sequencer that owns the program counter and drives the synchronous, one-cycle-latency instruction ROM (registered `read_en`/`addr` → `instruct`). It issues word-addressed reads and tracks the in-flight read. Returned instructions are buffered, with their PCs, in a small FIFO and presented to decode over a valid/ready handshake. A redirect from execute (branch, jump) flushes everything in flight. It sits between the instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instruction_fetch.sv | 93 +++++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Types and default widths shared by the instruction fetch sequencer and its buffer.
package fetch_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 2;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] instr;
      logic [ADDR_WIDTH_DEF-1:0] pc;
   } fetch_entry_t;

   // Width of an occupancy counter that must represent 0..depth inclusive.
   function automatic int count_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush outranks push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = FIFO_DEPTH_DEF,
   parameter type entry_t = fetch_entry_t,
   localparam int CW      = count_bits(DEPTH),
   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  entry_t        wr_data,
   output entry_t        head,
   output logic [CW-1:0] count
);

   entry_t          mem [DEPTH];
   logic   [PW-1:0] rd_ptr;
   logic   [PW-1:0] wr_ptr;
   logic            empty;
   logic            full;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: owns the PC, issues ROM reads, tracks the in-flight read and
// buffers returned instructions for decode behind a credit check.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  mem_read_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_instruct,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instruct,
   output logic [ADDR_WIDTH-1:0] out_pc
);

   localparam int CW = count_bits(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pending_pc;
   logic                  pending;
   logic [CW-1:0]         count;
   logic [CW:0]           in_use;
   logic                  pop;
   logic                  issue;
   entry_t                head;
   entry_t                capture;

   assign pop       = out_valid && out_ready;
   assign out_valid = (count != '0);

   // Slots committed after this cycle: buffered + in flight - leaving now.
   // A pop implies count >= 1, so this cannot underflow.
   assign in_use = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);

   // rst_n gates the strobe so no read is requested while reset is held.
   assign issue = rst_n && fetch_en && !redirect_valid &&
                  (in_use < (CW+1)'(FIFO_DEPTH));

   assign mem_read_en = issue;
   assign mem_addr    = pc;

   assign capture.instr = mem_instruct;
   assign capture.pc    = pending_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         pending    <= 1'b0;
         pending_pc <= '0;
      end else if (redirect_valid) begin
         pc      <= redirect_pc;
         pending <= 1'b0;
      end else begin
         pending <= issue;
         if (issue) begin
            pending_pc <= pc;
            pc         <= pc + 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (pending && !redirect_valid),
      .pop     (pop && !redirect_valid),
      .flush   (redirect_valid),
      .wr_data (capture),
      .head    (head),
      .count   (count)
   );

   assign out_instruct = head.instr;
   assign out_pc       = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency ROM model (ROM[n] = n ^ 0xA5A5).
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        mem_read_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_instruct;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instruct;
   logic [15:0] out_pc;

   int checks = 0;
   int errors = 0;

   instruction_fetch #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .RESET_PC   (16'h0010),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_read_en    (mem_read_en),
      .mem_addr       (mem_addr),
      .mem_instruct   (mem_instruct),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instruct   (out_instruct),
      .out_pc         (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (mem_read_en) begin
         mem_instruct <= mem_addr ^ 16'hA5A5;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, apply inputs, then sample 1ns later.
   task automatic cyc(input logic fe, input logic rv, input logic [15:0] rpc, input logic rdy);
      @(negedge clk);
      fetch_en       = fe;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      $display("t=%0t fe=%b rv=%b rdy=%b rd_en=%b addr=%h | valid=%b pc=%h instr=%h",
               $time, fetch_en, redirect_valid, out_ready, mem_read_en, mem_addr,
               out_valid, out_pc, out_instruct);
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [15:0] pc);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
      if (v) begin
         chk({tag, ".out_pc"}, {16'd0, out_pc}, {16'd0, pc});
         chk({tag, ".out_instruct"}, {16'd0, out_instruct}, {16'd0, pc ^ 16'hA5A5});
      end
   endtask

   task automatic expect_mem(input string tag, input logic en, input logic [15:0] addr);
      chk({tag, ".mem_read_en"}, {31'd0, mem_read_en}, {31'd0, en});
      chk({tag, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, addr});
   endtask

   task automatic expect_reset(input string tag);
      chk({tag, ".mem_read_en"}, {31'd0, mem_read_en}, 32'd0);
      chk({tag, ".mem_addr"}, {16'd0, mem_addr}, 32'h0010);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".out_instruct"}, {16'd0, out_instruct}, 32'd0);
      chk({tag, ".out_pc"}, {16'd0, out_pc}, 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      fetch_en       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      out_ready      = 1'b1;

      // Reset held with fetch_en high: no read may be requested.
      @(negedge clk);
      #1;
      expect_reset("reset");

      // Startup stream, out_ready high.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expect_mem("c0", 1'b1, 16'h0010);
      expect_out("c0", 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_mem("c1", 1'b1, 16'h0011);
      expect_out("c1", 1'b0, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b1);
         expect_out($sformatf("stream%0d", k), 1'b1, 16'h0010 + 16'(k));
         expect_mem($sformatf("stream%0d", k), 1'b1, 16'h0012 + 16'(k));
      end

      // Redirect to 0x0200 mid-stream.
      cyc(1'b1, 1'b1, 16'h0200, 1'b1);
      expect_mem("redir", 1'b0, 16'h0017);
      expect_out("redir", 1'b1, 16'h0015);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("redir+1", 1'b0, 16'h0000);
      expect_mem("redir+1", 1'b1, 16'h0200);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("redir+2", 1'b0, 16'h0000);
      expect_mem("redir+2", 1'b1, 16'h0201);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("redir+3", 1'b1, 16'h0200);
      expect_mem("redir+3", 1'b1, 16'h0202);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("redir+4", 1'b1, 16'h0201);
      expect_mem("redir+4", 1'b1, 16'h0203);

      // Redirect near the top of the address space to exercise wrap.
      cyc(1'b1, 1'b1, 16'hFFFE, 1'b1);
      expect_out("wrap_r", 1'b1, 16'h0202);
      expect_mem("wrap_r", 1'b0, 16'h0204);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("wrap+1", 1'b0, 16'h0000);
      expect_mem("wrap+1", 1'b1, 16'hFFFE);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("wrap+2", 1'b0, 16'h0000);
      expect_mem("wrap+2", 1'b1, 16'hFFFF);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("wrap+3", 1'b1, 16'hFFFE);
      expect_mem("wrap+3", 1'b1, 16'h0000);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("wrap+4", 1'b1, 16'hFFFF);
      expect_mem("wrap+4", 1'b1, 16'h0001);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("wrap+5", 1'b1, 16'h0000);
      expect_mem("wrap+5", 1'b1, 16'h0002);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("wrap+6", 1'b1, 16'h0001);
      expect_mem("wrap+6", 1'b1, 16'h0003);

      // Fetch pause for 4 cycles: pending read 0x0003 still delivered.
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      expect_out("pause0", 1'b1, 16'h0002);
      expect_mem("pause0", 1'b0, 16'h0004);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      expect_out("pause1", 1'b1, 16'h0003);
      expect_mem("pause1", 1'b0, 16'h0004);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      expect_out("pause2", 1'b0, 16'h0000);
      expect_mem("pause2", 1'b0, 16'h0004);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      expect_out("pause3", 1'b0, 16'h0000);
      expect_mem("pause3", 1'b0, 16'h0004);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("resume0", 1'b0, 16'h0000);
      expect_mem("resume0", 1'b1, 16'h0004);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("resume1", 1'b0, 16'h0000);
      expect_mem("resume1", 1'b1, 16'h0005);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("resume2", 1'b1, 16'h0004);
      expect_mem("resume2", 1'b1, 16'h0006);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("resume3", 1'b1, 16'h0005);
      expect_mem("resume3", 1'b1, 16'h0007);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("pre_rst", 1'b1, 16'h0006);
      expect_mem("pre_rst", 1'b1, 16'h0008);

      // Asynchronous reset between edges with one entry buffered and a read pending.
      #1;
      rst_n = 1'b0;
      #1;
      expect_reset("async_rst");

      // Restart with backpressure: out_ready low for 5 cycles after first valid.
      @(negedge clk);
      rst_n     = 1'b1;
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      #1;
      expect_mem("bp_c0", 1'b1, 16'h0010);
      expect_out("bp_c0", 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      expect_mem("bp_c1", 1'b1, 16'h0011);
      expect_out("bp_c1", 1'b0, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b0);
         expect_out($sformatf("bp_hold%0d", k), 1'b1, 16'h0010);
         expect_mem($sformatf("bp_hold%0d", k), 1'b0, 16'h0012);
      end
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("bp_rel0", 1'b1, 16'h0010);
      expect_mem("bp_rel0", 1'b1, 16'h0012);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("bp_rel1", 1'b1, 16'h0011);
      expect_mem("bp_rel1", 1'b1, 16'h0013);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("bp_rel2", 1'b1, 16'h0012);
      expect_mem("bp_rel2", 1'b1, 16'h0014);
      cyc(1'b1, 1'b0, 16'h0000, 1'b1);
      expect_out("bp_rel3", 1'b1, 16'h0013);
      expect_mem("bp_rel3", 1'b1, 16'h0015);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
